// File: rtl/ref_calib_scheduler.sv
// ref_calib_scheduler
// Sequences a set of ADC channels through a calibration round: for each
// channel selected in the latched mask it waits a settle time, pulses the
// accumulator clear, enables accumulation for a fixed number of cycles and
// captures the accumulator I/Q result into a per-channel slot.  A round is
// launched by a one-clock second-pulse edge and ends with a one-cycle done
// pulse.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   enable             run enable; low forces the scheduler idle
//   ch_mask            channels included in a round
//   settle_len         settle cycles minus one
//   acc_len            accumulation cycles per channel (0 behaves as 1)
//   sec_pulse_ed       round start strobe
//   acc_i, acc_q       signed accumulator results from the datapath
//   rd_ch              result read channel
//   sel                datapath input-channel select
//   acc_clr, acc_en    accumulator clear / enable
//   busy, done         round in progress / end-of-round pulse
//   overrun            sticky: start strobe arrived during a round
//   round_cnt          completed rounds (wrapping)
//   rd_i, rd_q         stored result for rd_ch (registered)
//   rd_valid           rd_ch result captured in the current round
module ref_calib_scheduler #(
  parameter int NCH   = 4,
  parameter int CH_W  = 2,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [NCH-1:0]          ch_mask,
  input  logic [7:0]              settle_len,
  input  logic [LEN_W-1:0]        acc_len,
  input  logic                    sec_pulse_ed,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [ACC_W-1:0] acc_q,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [CH_W-1:0]         sel,
  output logic                    acc_clr,
  output logic                    acc_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [15:0]             round_cnt,
  output logic signed [ACC_W-1:0] rd_i,
  output logic signed [ACC_W-1:0] rd_q,
  output logic                    rd_valid
);

  // The shared cycle counter covers both the 8-bit settle time and the
  // accumulation length.
  localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;
  // Result storage is sized to the full rd_ch range so any read index is
  // legal; slots above NCH are never written and read back as zero.
  localparam int NSLOT = 1 << CH_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [7:0]       settle_q, settle_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [NSLOT-1:0] valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      round_q, round_d;

  logic signed [ACC_W-1:0] slot_i_q [NSLOT];
  logic signed [ACC_W-1:0] slot_q_q [NSLOT];
  logic signed [ACC_W-1:0] rd_i_q, rd_q_q;
  logic                    rd_valid_q;

  logic [CH_W-1:0] first_sel;
  logic [CH_W-1:0] next_sel;
  logic            has_next;
  logic            settle_last;
  logic            accum_last;
  logic            capture_en;

  // State and control registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      mask_q    <= '0;
      settle_q  <= '0;
      len_q     <= '0;
      valid_q   <= '0;
      overrun_q <= 1'b0;
      round_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      settle_q  <= settle_d;
      len_q     <= len_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      round_q   <= round_d;
    end
  end

  // Channel ordering: lowest set bit of the incoming mask starts a round,
  // and the lowest latched bit above the current channel comes next.
  // Both loops scan downward so the last hit is the lowest qualifying bit.
  always_comb begin
    first_sel = '0;
    next_sel  = sel_q;
    has_next  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_sel = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_sel = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

  assign settle_last = (cnt_q == CNT_W'(settle_q));
  assign accum_last  = (cnt_q == CNT_W'(len_q) - CNT_W'(1));
  assign capture_en  = enable && (state_q == ST_CAPTURE);

  // Next-state logic.  Dropping enable overrides everything and also
  // clears the sticky overrun flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    settle_d  = settle_q;
    len_d     = len_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    round_d   = round_q;
    if (!enable) begin
      state_d   = ST_IDLE;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ch_mask != '0) state_d = ST_ARM;
        end
        ST_ARM: begin
          // An empty mask would give a round with nothing to do, so the
          // strobe is only accepted when at least one channel is selected.
          if (sec_pulse_ed && (ch_mask != '0)) begin
            mask_d   = ch_mask;
            settle_d = settle_len;
            len_d    = (acc_len == '0) ? LEN_W'(1) : acc_len;
            valid_d  = '0;
            sel_d    = first_sel;
            cnt_d    = '0;
            state_d  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_last) begin
            cnt_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ACCUM: begin
          if (accum_last) begin
            cnt_d   = '0;
            state_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          valid_d[sel_q] = 1'b1;
          if (has_next) begin
            sel_d   = next_sel;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          round_d = round_q + 16'd1;
          state_d = ST_ARM;
        end
        default: state_d = ST_IDLE;
      endcase
      // A strobe during a round never disturbs it; it is only flagged.
      if (sec_pulse_ed && (state_q inside {ST_SETTLE, ST_ACCUM, ST_CAPTURE, ST_DONE})) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    sel       = sel_q;
    acc_clr   = (state_q == ST_SETTLE) && settle_last;
    acc_en    = (state_q == ST_ACCUM);
    busy      = (state_q inside {ST_SETTLE, ST_ACCUM, ST_CAPTURE, ST_DONE});
    done      = (state_q == ST_DONE);
    overrun   = overrun_q;
    round_cnt = round_q;
    rd_i      = rd_i_q;
    rd_q      = rd_q_q;
    rd_valid  = rd_valid_q;
  end

  // Result slots and the registered read port.  The read samples the slot
  // contents before any capture on the same edge, so a read racing a
  // capture of its own slot returns the older value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NSLOT; i++) begin
        slot_i_q[i] <= '0;
        slot_q_q[i] <= '0;
      end
      rd_i_q     <= '0;
      rd_q_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (capture_en) begin
        slot_i_q[sel_q] <= acc_i;
        slot_q_q[sel_q] <= acc_q;
      end
      rd_i_q     <= slot_i_q[rd_ch];
      rd_q_q     <= slot_q_q[rd_ch];
      rd_valid_q <= valid_q[rd_ch];
    end
  end

endmodule

// File: tb/tb_ref_calib_scheduler.sv
// tb_ref_calib_scheduler
// Self-checking bench for ref_calib_scheduler.  Each round is described by
// an expected cycle timeline built from the channel mask, settle time and
// accumulation length; outputs are compared cycle by cycle against it, and
// a per-channel result model tracks captured I/Q data and valid bits for
// the registered read port.  Inputs change on the falling edge and outputs
// are sampled there too.
module tb_ref_calib_scheduler;

  logic               clk;
  logic               resetn;
  logic               enable;
  logic [3:0]         ch_mask;
  logic [7:0]         settle_len;
  logic [15:0]        acc_len;
  logic               sec_pulse_ed;
  logic signed [31:0] acc_i;
  logic signed [31:0] acc_q;
  logic [1:0]         rd_ch;
  logic [1:0]         sel;
  logic               acc_clr;
  logic               acc_en;
  logic               busy;
  logic               done;
  logic               overrun;
  logic [15:0]        round_cnt;
  logic signed [31:0] rd_i;
  logic signed [31:0] rd_q;
  logic               rd_valid;

  int nVec = 0;
  int nErr = 0;

  // Reference model state.
  logic [31:0] mI [4];
  logic [31:0] mQ [4];
  bit          mV [4];
  int          rc;
  bit          mOvr;
  logic [31:0] eI, eQ;
  bit          eV;

  // Expected timeline of one round, one entry per busy cycle.
  int tSel[$];
  bit tEn[$];
  bit tClr[$];
  bit tCap[$];
  bit tDone[$];

  ref_calib_scheduler #(
    .NCH(4), .CH_W(2), .ACC_W(32), .LEN_W(16)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .ch_mask(ch_mask),
    .settle_len(settle_len), .acc_len(acc_len), .sec_pulse_ed(sec_pulse_ed),
    .acc_i(acc_i), .acc_q(acc_q), .rd_ch(rd_ch), .sel(sel),
    .acc_clr(acc_clr), .acc_en(acc_en), .busy(busy), .done(done),
    .overrun(overrun), .round_cnt(round_cnt), .rd_i(rd_i), .rd_q(rd_q),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int c = 0; c < 4; c++) begin
      mI[c] = '0;
      mQ[c] = '0;
      mV[c] = 1'b0;
    end
    rc   = 0;
    mOvr = 1'b0;
    eI   = '0;
    eQ   = '0;
    eV   = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".sel"}, 32'(sel), 32'd0);
    checkOutput({tag, ".acc_clr"}, 32'(acc_clr), 32'd0);
    checkOutput({tag, ".acc_en"}, 32'(acc_en), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
    checkOutput({tag, ".overrun"}, 32'(overrun), 32'd0);
    checkOutput({tag, ".round_cnt"}, 32'(round_cnt), 32'd0);
    checkOutput({tag, ".rd_i"}, rd_i, 32'd0);
    checkOutput({tag, ".rd_q"}, rd_q, 32'd0);
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
  endtask

  // Checks the read data requested last cycle, then issues a new random
  // read whose answer is the model contents before this edge's updates.
  task automatic rdStep(input string tag);
    checkOutput({tag, ".rd_i"}, rd_i, eI);
    checkOutput({tag, ".rd_q"}, rd_q, eQ);
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(eV));
    rd_ch = 2'($urandom_range(0, 3));
    eI = mI[rd_ch];
    eQ = mQ[rd_ch];
    eV = mV[rd_ch];
  endtask

  // Directed read of one channel while no round is running.
  task automatic readCheck(input int ch, input string tag);
    @(negedge clk);
    rd_ch = 2'(ch);
    @(negedge clk);
    checkOutput({tag, ".rd_i"}, rd_i, mI[ch]);
    checkOutput({tag, ".rd_q"}, rd_q, mQ[ch]);
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(mV[ch]));
    eI = mI[ch];
    eQ = mQ[ch];
    eV = mV[ch];
  endtask

  // Moves the scheduler from idle to armed.
  task automatic goArm();
    @(negedge clk);
    enable  = 1'b1;
    ch_mask = 4'b0001;
    @(negedge clk);
  endtask

  // Runs one round from the armed state.  ovrAt injects a second start
  // strobe at that timeline index; resetAt pulls reset at that index.
  task automatic applyStimulus(input logic [3:0] m, input logic [7:0] st, input logic [15:0] al,
                               input bit fixedData, input int ovrAt, input int resetAt, input string tag);
    int alen;
    int lastCh;
    string et;
    tSel.delete(); tEn.delete(); tClr.delete(); tCap.delete(); tDone.delete();
    alen   = (al == 16'd0) ? 1 : int'(al);
    lastCh = 0;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        lastCh = c;
        for (int s = 0; s <= int'(st); s++) begin
          tSel.push_back(c); tEn.push_back(0); tClr.push_back(s == int'(st)); tCap.push_back(0); tDone.push_back(0);
        end
        for (int a = 0; a < alen; a++) begin
          tSel.push_back(c); tEn.push_back(1); tClr.push_back(0); tCap.push_back(0); tDone.push_back(0);
        end
        tSel.push_back(c); tEn.push_back(0); tClr.push_back(0); tCap.push_back(1); tDone.push_back(0);
      end
    end
    tSel.push_back(lastCh); tEn.push_back(0); tClr.push_back(0); tCap.push_back(0); tDone.push_back(1);

    // Armed cycle: present the configuration and the start strobe.
    @(negedge clk);
    checkOutput({tag, ".arm.busy"}, 32'(busy), 32'd0);
    ch_mask      = m;
    settle_len   = st;
    acc_len      = al;
    sec_pulse_ed = 1'b1;
    acc_i = fixedData ? 32'sd123 : $urandom;
    acc_q = fixedData ? -32'sd45 : $urandom;
    rdStep({tag, ".arm"});
    for (int c = 0; c < 4; c++) mV[c] = 1'b0;

    for (int k = 0; k < tSel.size(); k++) begin
      @(negedge clk);
      et = $sformatf("%s.c%0d", tag, k);
      if (k == resetAt) begin
        resetn       = 1'b0;
        sec_pulse_ed = 1'b0;
        #1;
        checkResetOutputs({et, ".rst"});
        resetModel();
        repeat (2) begin
          @(negedge clk);
          checkOutput({et, ".rst.done"}, 32'(done), 32'd0);
        end
        resetn = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          checkOutput({et, ".post.done"}, 32'(done), 32'd0);
          checkOutput({et, ".post.busy"}, 32'(busy), 32'd0);
          checkOutput({et, ".post.round_cnt"}, 32'(round_cnt), 32'd0);
        end
        return;
      end
      sec_pulse_ed = (k == ovrAt);
      checkOutput({et, ".sel"}, 32'(sel), 32'(tSel[k]));
      checkOutput({et, ".acc_en"}, 32'(acc_en), 32'(tEn[k]));
      checkOutput({et, ".acc_clr"}, 32'(acc_clr), 32'(tClr[k]));
      checkOutput({et, ".done"}, 32'(done), 32'(tDone[k]));
      checkOutput({et, ".busy"}, 32'(busy), 32'd1);
      checkOutput({et, ".overrun"}, 32'(overrun), 32'(mOvr));
      checkOutput({et, ".round_cnt"}, 32'(round_cnt), 32'(rc & 16'hFFFF));
      rdStep(et);
      // Configuration inputs wander during the round; the latched copy rules.
      ch_mask    = 4'($urandom);
      settle_len = 8'($urandom_range(0, 9));
      acc_len    = 16'($urandom_range(0, 9));
      acc_i = fixedData ? 32'sd123 : $urandom;
      acc_q = fixedData ? -32'sd45 : $urandom;
      if (tCap[k]) begin
        mI[tSel[k]] = acc_i;
        mQ[tSel[k]] = acc_q;
        mV[tSel[k]] = 1'b1;
      end
      if (tDone[k]) rc++;
      if (k == ovrAt) mOvr = 1'b1;
    end

    @(negedge clk);
    sec_pulse_ed = 1'b0;
    checkOutput({tag, ".end.busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".end.done"}, 32'(done), 32'd0);
    checkOutput({tag, ".end.acc_en"}, 32'(acc_en), 32'd0);
    checkOutput({tag, ".end.round_cnt"}, 32'(round_cnt), 32'(rc & 16'hFFFF));
    checkOutput({tag, ".end.overrun"}, 32'(overrun), 32'(mOvr));
    rdStep({tag, ".end"});
  endtask

  initial begin
    resetn       = 1'b0;
    enable       = 1'b0;
    ch_mask      = 4'b0000;
    settle_len   = 8'd0;
    acc_len      = 16'd0;
    sec_pulse_ed = 1'b0;
    acc_i        = '0;
    acc_q        = '0;
    rd_ch        = 2'd0;
    resetModel();

    @(negedge clk);
    checkResetOutputs("reset");
    resetn  = 1'b1;
    enable  = 1'b1;
    ch_mask = 4'b0101;
    @(negedge clk);

    $display("[TB] two-channel round with constant data");
    applyStimulus(4'b0101, 8'd3, 16'd10, 1'b1, -1, -1, "basic");
    readCheck(2, "rd2");
    checkOutput("rd2.const_i", rd_i, 32'd123);
    checkOutput("rd2.const_q", rd_q, 32'hFFFF_FFD3);
    checkOutput("rd2.const_v", 32'(rd_valid), 32'd1);
    readCheck(1, "rd1");
    checkOutput("rd1.const_v", 32'(rd_valid), 32'd0);

    $display("[TB] overrun during a round, then disable");
    applyStimulus(4'b0101, 8'd3, 16'd10, 1'b0, 4, -1, "ovr");
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    mOvr = 1'b0;
    checkOutput("dis.overrun", 32'(overrun), 32'd0);
    checkOutput("dis.busy", 32'(busy), 32'd0);
    // From idle a strobe is not accepted; only the move to armed happens.
    enable       = 1'b1;
    ch_mask      = 4'b0001;
    sec_pulse_ed = 1'b1;
    @(negedge clk);
    sec_pulse_ed = 1'b0;
    checkOutput("idle.busy0", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("idle.busy1", 32'(busy), 32'd0);
    checkOutput("idle.acc_en", 32'(acc_en), 32'd0);

    $display("[TB] empty mask never starts a round");
    enable = 1'b0;
    @(negedge clk);
    enable       = 1'b1;
    ch_mask      = 4'b0000;
    sec_pulse_ed = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      sec_pulse_ed = (j == 1);
      checkOutput($sformatf("empty.busy%0d", j), 32'(busy), 32'd0);
      checkOutput($sformatf("empty.acc_en%0d", j), 32'(acc_en), 32'd0);
      checkOutput($sformatf("empty.done%0d", j), 32'(done), 32'd0);
    end
    sec_pulse_ed = 1'b0;
    goArm();

    $display("[TB] reset during accumulation");
    applyStimulus(4'b0101, 8'd3, 16'd10, 1'b0, -1, 7, "rstacc");
    goArm();

    $display("[TB] minimum lengths on the top channel");
    applyStimulus(4'b1000, 8'd0, 16'd0, 1'b0, -1, -1, "min");
    readCheck(3, "min.rd3");

    $display("[TB] random rounds");
    for (int r = 0; r < 24; r++) begin
      logic [3:0] m;
      logic [7:0] st;
      logic [15:0] al;
      int ov;
      m  = 4'($urandom_range(1, 15));
      st = 8'($urandom_range(0, 4));
      al = 16'($urandom_range(0, 5));
      ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      applyStimulus(m, st, al, 1'b0, ov, -1, $sformatf("rnd%0d", r));
      readCheck(int'($urandom_range(0, 3)), $sformatf("rnd%0d.rd", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
